// File: rtl/apes_pkg.sv
// apes_pkg: shared constants and FSM state encoding for the APES readout frame builder.
package apes_pkg;
    localparam logic [7:0] SYNC0_BYTE = 8'hEB;
    localparam logic [7:0] SYNC1_BYTE = 8'h90;
    localparam int         NUM_CH     = 8;
    localparam int         FRAME_LEN  = 20;
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SYNC0   = 4'd1;
    localparam logic [3:0] S_SYNC1   = 4'd2;
    localparam logic [3:0] S_SEQ     = 4'd3;
    localparam logic [3:0] S_FETCH   = 4'd4;
    localparam logic [3:0] S_DHI     = 4'd5;
    localparam logic [3:0] S_DLO     = 4'd6;
    localparam logic [3:0] S_CKSUM   = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;
    localparam logic [3:0] S_WAITLOW = 4'd9;
endpackage

// File: rtl/apes_tx_reg.sv
// apes_tx_reg: one-byte valid/ready holding register feeding the telemetry link.
module apes_tx_reg (
    input  logic       clk50,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       xfer_o
);
    logic [7:0] data_q;
    logic       valid_q;
    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign xfer_o   = valid_q & tx_ready;
    // load only happens while empty or on the accepting cycle, so a pending byte is never overwritten
    always_ff @(posedge clk50) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (xfer_o) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/apes_rdout.sv
// apes_rdout: reads 8 counters and streams a 20-byte sync/seq/data/checksum frame per enable.
module apes_rdout
    import apes_pkg::*;
(
    input  logic        clk50,
    input  logic        rst,
    input  logic        en_rocket_rd,
    output logic [2:0]  cnt_addr,
    input  logic [15:0] cnt_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rdout_done,
    output logic [7:0]  frame_seq
);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    logic [3:0] state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] lo_q, lo_d, cksum_q, cksum_d, seq_q, seq_d;
    logic       fwait_q, fwait_d, done_q, done_d;
    logic       load, xfer;
    logic [7:0] load_data;
    assign cnt_addr   = addr_q;
    assign rdout_done = done_q;
    assign frame_seq  = seq_q;
    apes_tx_reg u_tx (
        .clk50    (clk50),
        .rst      (rst),
        .load_i   (load),
        .data_i   (load_data),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .xfer_o   (xfer)
    );
    // the checksum absorbs each byte as it is loaded, so it is complete when the last low byte goes out
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        cksum_d   = cksum_q;
        seq_d     = seq_q;
        fwait_d   = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        case (state_q)
            S_IDLE: if (en_rocket_rd) begin
                state_d = S_SYNC0; load = 1'b1; load_data = SYNC0_BYTE; cksum_d = 8'h00;
            end
            S_SYNC0: if (xfer) begin
                state_d = S_SYNC1; load = 1'b1; load_data = SYNC1_BYTE;
            end
            S_SYNC1: if (xfer) begin
                state_d = S_SEQ; load = 1'b1; load_data = seq_q; cksum_d = cksum_q + seq_q;
            end
            S_SEQ: if (xfer) begin
                state_d = S_FETCH; addr_d = 3'd0;
            end
            // first FETCH cycle lets cnt_data settle on the new address, the second captures it
            S_FETCH: begin
                fwait_d = ~fwait_q;
                if (fwait_q) begin
                    state_d = S_DHI; load = 1'b1; load_data = cnt_data[15:8];
                    lo_d = cnt_data[7:0]; cksum_d = cksum_q + cnt_data[15:8];
                end
            end
            S_DHI: if (xfer) begin
                state_d = S_DLO; load = 1'b1; load_data = lo_q; cksum_d = cksum_q + lo_q;
            end
            S_DLO: if (xfer) begin
                if (addr_q == LAST_CH) begin
                    state_d = S_CKSUM; load = 1'b1; load_data = cksum_q;
                end else begin
                    state_d = S_FETCH; addr_d = addr_q + 3'd1;
                end
            end
            S_CKSUM: if (xfer) begin
                state_d = S_DONE; done_d = 1'b1; seq_d = seq_q + 8'd1;
            end
            S_DONE:    state_d = S_WAITLOW;
            S_WAITLOW: state_d = en_rocket_rd ? S_WAITLOW : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 3'd0;
            lo_q    <= 8'h00;
            cksum_q <= 8'h00;
            seq_q   <= 8'h00;
            fwait_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            cksum_q <= cksum_d;
            seq_q   <= seq_d;
            fwait_q <= fwait_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/apes_rdout.md
APES_RDOUT -- requirements
Module: apes_rdout

Interface
REQ-001 SHALL declare port clk50  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL declare port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL declare port en_rocket_rd  input  1  readout enable from the collection FSM.
REQ-004 SHALL declare port cnt_addr  output  3  channel select to the counter bank.
REQ-005 SHALL declare port cnt_data  input  16  counter value; valid one clk50 after cnt_addr changes.
REQ-006 SHALL declare port tx_data  output  8  frame byte to the telemetry link.
REQ-007 SHALL declare port tx_valid  output  1  tx_data holds a valid byte.
REQ-008 SHALL declare port tx_ready  input  1  link accepts the byte this cycle.
REQ-009 SHALL declare port rdout_done  output  1  one-cycle pulse; frame fully transferred.
REQ-010 SHALL declare port frame_seq  output  8  sequence number of the next frame.

Function
REQ-011 SHALL emit a 20-byte frame: 0xEB, 0x90, frame_seq, channels 0..7 (each 16-bit, MSB first), checksum.
REQ-012 SHALL compute the checksum as the mod-256 sum of bytes 3..19 (seq plus all data bytes); sync bytes excluded.
REQ-013 SHALL transfer a byte only on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-014 SHALL drive all outputs from registers; no combinational path from tx_ready to tx_valid or tx_data.
REQ-015 SHALL implement states IDLE, SYNC0, SYNC1, SEQ, FETCH, DHI, DLO, CKSUM, DONE, WAITLOW.
REQ-016 In IDLE, if en_rocket_rd=1, SHALL go to SYNC0 next cycle with tx_valid=1 and tx_data=0xEB; the checksum accumulator SHALL clear.
REQ-017 SYNC0, SYNC1, SEQ, DHI, DLO and CKSUM SHALL each hold until a transfer, then advance.
REQ-018 SEQ SHALL advance to FETCH; DLO SHALL advance to FETCH for channels 0..6 and to CKSUM after channel 7.
REQ-019 FETCH SHALL drive cnt_addr with the channel index and deassert tx_valid; it SHALL capture cnt_data one cycle later, then enter DHI presenting the high byte.
REQ-020 After the CKSUM transfer, SHALL enter DONE: rdout_done=1 for exactly one cycle, and frame_seq SHALL increment modulo 256 (255 -> 0).
REQ-021 WAITLOW SHALL remain until en_rocket_rd=0, then go to IDLE; a frame SHALL never retrigger from a single enable assertion.
REQ-022 en_rocket_rd SHALL be sampled only in IDLE and WAITLOW; deassertion mid-frame SHALL NOT abort the frame.
REQ-023 cnt_addr SHALL hold its last value outside FETCH.
REQ-024 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-025 With rst=1 at a clock edge, the next state SHALL be IDLE with tx_valid=0, tx_data=0x00, rdout_done=0, cnt_addr=0, frame_seq=0 and checksum=0.
REQ-026 Reset mid-frame SHALL drop tx_valid the following cycle; no partial frame SHALL resume after reset.

Structure
REQ-027 Package apes_pkg SHALL hold SYNC0_BYTE=0xEB, SYNC1_BYTE=0x90, NUM_CH=8, FRAME_LEN=20 and the state encoding.
REQ-028 SHALL contain one sub-module, apes_tx_reg: an 8-bit valid/ready holding register that owns tx_data and tx_valid.

Verification
REQ-029 SHALL cover: channels = 0x0001..0x0008, tx_ready=1 constantly, one en_rocket_rd pulse -> bytes EB 90 00 00 01 00 02 .. 00 08 24, then one rdout_done pulse.
REQ-030 SHALL cover: the same frame with tx_ready toggled pseudo-randomly -> identical byte sequence, and tx_data never changes while stalled.
REQ-031 SHALL cover: all channels = 0xFFFF, seq=0x05 -> checksum 0x05 + 16×0xFF mod 256 = 0xF5.
REQ-032 SHALL cover: en_rocket_rd held high for 100 cycles after DONE -> no second frame; after a low then high transition -> second frame with seq=0x01.
REQ-033 SHALL cover: 256 frames -> seq byte wraps 0xFF -> 0x00.
REQ-034 SHALL cover: rst asserted after byte 7 -> tx_valid=0 next cycle, frame_seq=0, and the next frame starts at 0xEB.
